// File: rtl/switch_arb_pkg.sv
// Shared types for the output-port arbiter: FSM states, default port count and
// the port-index type.
package switch_arb_pkg;
  localparam int NUM_PORTS_DEF = 4;
  localparam int PORT_IDX_W    = (NUM_PORTS_DEF > 1) ? $clog2(NUM_PORTS_DEF) : 1;

  typedef logic [PORT_IDX_W-1:0] port_idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  // Index width for an arbitrary port count; a single port still needs one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/switch_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first requesting input at or after rr_ptr,
// wrapping modulo NUM_PORTS.
module rr_pick
  import switch_arb_pkg::*;
#(
  parameter  int NUM_PORTS = NUM_PORTS_DEF,
  localparam int IW        = idx_w(NUM_PORTS)
) (
  input  logic [NUM_PORTS-1:0] req,
  input  logic [IW-1:0]        rr_ptr,
  output logic [IW-1:0]        winner,
  output logic                 any
);

  // Walk offsets from farthest to nearest so the nearest requester wins.
  always_comb begin
    winner = '0;
    any    = |req;
    for (int j = NUM_PORTS - 1; j >= 0; j--) begin
      if (req[(int'(rr_ptr) + j) % NUM_PORTS])
        winner = IW'((int'(rr_ptr) + j) % NUM_PORTS);
    end
  end

endmodule

// File: rtl/switch_out_arbiter.sv
// Output-port arbiter: round-robin grant held for a whole packet, released on
// last beat, beat-count timeout, requester abort, or reset.
module switch_out_arbiter
  import switch_arb_pkg::*;
#(
  parameter  int NUM_PORTS = NUM_PORTS_DEF,
  parameter  int MAX_BEATS = 64,
  localparam int IW        = idx_w(NUM_PORTS)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_PORTS-1:0] req,
  input  logic [NUM_PORTS-1:0] beat_valid,
  input  logic [NUM_PORTS-1:0] beat_last,
  input  logic                 out_ready,
  output logic [NUM_PORTS-1:0] grant,
  output logic [IW-1:0]        grant_idx,
  output logic                 beat_fire,
  output logic                 timeout_err,
  output logic [15:0]          pkt_count
);

  localparam int CW = $clog2(MAX_BEATS + 1);

  arb_state_e      state;
  logic [IW-1:0]   rr_ptr;
  logic [CW-1:0]   beat_cnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_any;
  logic            grant_valid;
  logic            cur_last;
  logic            cnt_hit;
  logic [IW-1:0]   next_ptr;

  rr_pick #(.NUM_PORTS(NUM_PORTS)) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .winner (pick_idx),
    .any    (pick_any)
  );

  assign grant_valid = (state == LOCK);
  assign beat_fire   = grant_valid & beat_valid[grant_idx] & out_ready;
  assign cur_last    = beat_last[grant_idx];
  // This fire would be beat number MAX_BEATS.
  assign cnt_hit     = (beat_cnt == CW'(MAX_BEATS - 1));
  assign next_ptr    = (grant_idx == IW'(NUM_PORTS - 1)) ? '0 : grant_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      grant       <= '0;
      grant_idx   <= '0;
      rr_ptr      <= '0;
      beat_cnt    <= '0;
      timeout_err <= 1'b0;
      pkt_count   <= '0;
    end else begin
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (pick_any) begin
            state     <= LOCK;
            grant_idx <= pick_idx;
            grant     <= NUM_PORTS'(1) << pick_idx;
            beat_cnt  <= '0;
          end
        end
        LOCK: begin
          // A last beat wins over both the timeout and a same-cycle req drop.
          if ((beat_fire && cur_last) || (beat_fire && cnt_hit) || !req[grant_idx]) begin
            state     <= IDLE;
            grant     <= '0;
            grant_idx <= '0;
            beat_cnt  <= '0;
            rr_ptr    <= next_ptr;
            if (beat_fire && cur_last)
              pkt_count <= pkt_count + 16'd1;
            else if (beat_fire && cnt_hit)
              timeout_err <= 1'b1;
          end else if (beat_fire) begin
            beat_cnt <= beat_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_switch_out_arbiter.sv
// Directed + random bench; two arbiters (MAX_BEATS 64 and 4) share stimulus and
// are checked every cycle against a packet-level reference model.
module tb_switch_out_arbiter;
  localparam int NP = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic [NP-1:0] req, bv, bl;
  logic          ordy;
  logic [NP-1:0] g0, g1;
  logic [1:0]    gi0, gi1;
  logic          bf0, bf1, to0, to1;
  logic [15:0]   pc0, pc1;

  switch_out_arbiter #(.NUM_PORTS(NP), .MAX_BEATS(64)) u0 (
    .clk(clk), .rst(rst), .req(req), .beat_valid(bv), .beat_last(bl),
    .out_ready(ordy), .grant(g0), .grant_idx(gi0), .beat_fire(bf0),
    .timeout_err(to0), .pkt_count(pc0));

  switch_out_arbiter #(.NUM_PORTS(NP), .MAX_BEATS(4)) u1 (
    .clk(clk), .rst(rst), .req(req), .beat_valid(bv), .beat_last(bl),
    .out_ready(ordy), .grant(g1), .grant_idx(gi1), .beat_fire(bf1),
    .timeout_err(to1), .pkt_count(pc1));

  // Reference model: who owns the output, how many beats it has sent, where
  // the next search starts, and what has completed.
  int          busy  [2];
  int          owner [2];
  int          beats [2];
  int          ptr   [2];
  logic [15:0] pkts  [2];
  bit          tmo   [2];
  int          maxb  [2] = '{64, 4};

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      logic [NP-1:0] g, eg;
      logic [1:0]    gi;
      logic          bf, to, ebf;
      logic [15:0]   pc;
      g  = (k == 0) ? g0  : g1;
      gi = (k == 0) ? gi0 : gi1;
      bf = (k == 0) ? bf0 : bf1;
      to = (k == 0) ? to0 : to1;
      pc = (k == 0) ? pc0 : pc1;
      eg = '0;
      if (busy[k] != 0) eg[owner[k]] = 1'b1;
      ebf = (busy[k] != 0) && bv[owner[k]] && ordy;
      chk($sformatf("u%0d_grant", k),     32'(g),  32'(eg));
      chk($sformatf("u%0d_grant_idx", k), 32'(gi), (busy[k] != 0) ? 32'(owner[k]) : 32'd0);
      chk($sformatf("u%0d_beat_fire", k), 32'(bf), 32'(ebf));
      chk($sformatf("u%0d_timeout", k),   32'(to), 32'(tmo[k]));
      chk($sformatf("u%0d_pkt_count", k), 32'(pc), 32'(pkts[k]));
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 2; k++) begin
      bit fire, found;
      int nb;
      fire   = (busy[k] != 0) && bv[owner[k]] && ordy;
      tmo[k] = 1'b0;
      if (rst) begin
        busy[k] = 0; owner[k] = 0; beats[k] = 0; ptr[k] = 0; pkts[k] = '0;
      end else if (busy[k] == 0) begin
        found = 1'b0;
        for (int j = 0; j < NP; j++) begin
          if (!found && req[(ptr[k] + j) % NP]) begin
            owner[k] = (ptr[k] + j) % NP;
            found    = 1'b1;
          end
        end
        if (found) begin
          busy[k]  = 1;
          beats[k] = 0;
        end
      end else begin
        nb = beats[k] + (fire ? 1 : 0);
        if ((fire && bl[owner[k]]) || nb >= maxb[k] || !req[owner[k]]) begin
          if (fire && bl[owner[k]]) pkts[k] = pkts[k] + 16'd1;
          else if (nb >= maxb[k])   tmo[k]  = 1'b1;
          busy[k]  = 0;
          ptr[k]   = (owner[k] + 1) % NP;
          owner[k] = 0;
          beats[k] = 0;
        end else begin
          beats[k] = nb;
        end
      end
    end
  endtask

  task automatic cyc(input logic r, input logic [NP-1:0] rq, input logic [NP-1:0] v,
                     input logic [NP-1:0] l, input logic o);
    rst = r; req = rq; bv = v; bl = l; ordy = o;
    #1;
    check_all();
    @(posedge clk);
    model_step();
    @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      busy[k] = 0; owner[k] = 0; beats[k] = 0; ptr[k] = 0; pkts[k] = '0; tmo[k] = 1'b0;
    end
    rst = 1'b1; req = '0; bv = '0; bl = '0; ordy = 1'b0;
    @(negedge clk);
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("reset_grant", 32'(g0), 32'd0);
    chk("reset_pkt",   32'(pc0), 32'd0);

    // all ports requesting, single-beat packets: order 0,1,2,3,0
    cyc(1, 4'h0, 4'h0, 4'h0, 1);
    repeat (10) cyc(0, 4'hF, 4'hF, 4'hF, 1);

    // port 2 five-beat packet while everyone requests
    cyc(1, 4'h0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0100, 4'h0, 4'h0, 1);
    repeat (4) cyc(0, 4'hF, 4'hF, 4'h0, 1);
    cyc(0, 4'hF, 4'hF, 4'b0100, 1);
    repeat (3) cyc(0, 4'hF, 4'hF, 4'h0, 1);

    // port 1, out_ready stalls mid-packet
    cyc(1, 4'h0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0001, 4'h0, 4'h0, 1);
    cyc(0, 4'b0001, 4'b0001, 4'b0001, 1);
    cyc(0, 4'b0010, 4'h0, 4'h0, 1);
    cyc(0, 4'b0010, 4'b0010, 4'h0, 1);
    cyc(0, 4'b0010, 4'b0010, 4'h0, 0);
    cyc(0, 4'b0010, 4'b0010, 4'h0, 0);
    cyc(0, 4'b0010, 4'b0010, 4'h0, 1);
    cyc(0, 4'b0010, 4'b0010, 4'b0010, 1);
    repeat (2) cyc(0, 4'h0, 4'h0, 4'h0, 1);

    // port 0 never sends last: timeout on the MAX_BEATS=4 instance
    cyc(1, 4'h0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0001, 4'h0, 4'h0, 1);
    repeat (4) cyc(0, 4'b0011, 4'b0001, 4'h0, 1);
    repeat (3) cyc(0, 4'b0011, 4'hF, 4'h0, 1);

    // reset in the middle of port 3's packet
    cyc(1, 4'h0, 4'h0, 4'h0, 1);
    cyc(0, 4'b1000, 4'h0, 4'h0, 1);
    repeat (2) cyc(0, 4'b1000, 4'b1000, 4'h0, 1);
    cyc(1, 4'b1000, 4'b1000, 4'h0, 1);
    repeat (3) cyc(0, 4'hF, 4'hF, 4'hF, 1);

    // port 0 drops req mid-packet
    cyc(1, 4'h0, 4'h0, 4'h0, 1);
    cyc(0, 4'b0001, 4'h0, 4'h0, 1);
    cyc(0, 4'b0001, 4'b0001, 4'h0, 1);
    cyc(0, 4'b0000, 4'b0001, 4'h0, 1);
    repeat (3) cyc(0, 4'hF, 4'hF, 4'hF, 1);

    // random traffic
    for (int i = 0; i < 800; i++) begin
      logic [NP-1:0] rq, v, l;
      rq = NP'($urandom) | NP'($urandom);
      v  = NP'($urandom) | NP'($urandom);
      l  = NP'($urandom) & NP'($urandom);
      cyc(($urandom_range(0, 199) == 0), rq, v, l, ($urandom_range(0, 3) != 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/switch_out_arbiter.md
SWITCH_OUT_ARBITER -- requirements
Module: switch_out_arbiter

Interface
REQ-001 SHALL have parameter NUM_PORTS, default 4: number of input ports competing for one output port.
REQ-002 SHALL have parameter MAX_BEATS, default 64: maximum data beats per packet before forced release.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port req  input  NUM_PORTS  bit i high = input i holds a packet for this output.
REQ-006 SHALL have port beat_valid  input  NUM_PORTS  input i presents a data beat.
REQ-007 SHALL have port beat_last  input  NUM_PORTS  input i's beat is the final beat of its packet.
REQ-008 SHALL have port out_ready  input  1  downstream output accepts a beat this cycle.
REQ-009 SHALL have port grant  output  NUM_PORTS  one-hot grant; all-zero when idle.
REQ-010 SHALL have port grant_idx  output  log2(NUM_PORTS)  index of granted input; 0 when idle.
REQ-011 SHALL have port beat_fire  output  1  combinational: grant_valid & beat_valid[grant_idx] & out_ready.
REQ-012 SHALL have port timeout_err  output  1  one-cycle pulse on forced release.
REQ-013 SHALL have port pkt_count  output  16  completed packets since reset, wraps 0xFFFF->0.

Function
REQ-014 SHALL implement FSM states IDLE and LOCK; grant_valid = (state==LOCK).
REQ-015 IDLE: if any req bit high, SHALL select the winner by round-robin starting at rr_ptr, register it, enter LOCK; grant visible the cycle after req sampled (latency 1).
REQ-016 IDLE with req==0 SHALL remain IDLE; grant all-zero.
REQ-017 LOCK: grant SHALL hold on grant_idx regardless of other req bits (packet-granularity lock, no preemption).
REQ-018 beat_cnt (width covering MAX_BEATS) SHALL clear on LOCK entry and increment on each beat_fire.
REQ-019 beat_fire with beat_last[grant_idx] high SHALL: return to IDLE, increment pkt_count, set rr_ptr = grant_idx+1 mod NUM_PORTS.
REQ-020 If beat_cnt reaches MAX_BEATS without a last beat fired, SHALL pulse timeout_err, return to IDLE, advance rr_ptr as REQ-019; pkt_count unchanged.
REQ-021 Beat_fire with last on the same cycle beat_cnt reaches MAX_BEATS SHALL count as normal completion; no timeout_err.
REQ-022 If req[grant_idx] drops in LOCK before last fires, SHALL abort: return to IDLE, advance rr_ptr, no pkt_count increment, no timeout_err.
REQ-023 out_ready low SHALL stall: no beat_fire, beat_cnt and state hold.
REQ-024 Exactly one IDLE cycle SHALL separate consecutive grants (no back-to-back re-arbitration).
REQ-025 grant SHALL never have more than one bit set.

Reset
REQ-026 rst high at a clock edge SHALL force state=IDLE, grant=0, grant_idx=0, rr_ptr=0, beat_cnt=0, timeout_err=0, pkt_count=0.
REQ-027 rst asserted mid-packet SHALL drop grant at that edge; the partial packet SHALL not be counted.
REQ-028 First arbitration after reset SHALL favour input 0.

Structure
REQ-029 Shared package switch_arb_pkg SHALL hold the state enum, NUM_PORTS default and port-index typedef.
REQ-030 Round-robin selection SHALL be a combinational sub-module rr_pick (inputs req, rr_ptr; outputs winner index, any).

Verification
REQ-031 Reset, req=4'b1111, all beats single-beat last, out_ready=1 -> grant order 0,1,2,3,0; pkt_count=4 after four packets.
REQ-032 Input 2 sends 5-beat packet while req=4'b1111 -> grant stays 4'b0100 for 5 fires, then 4'b1000 after one IDLE cycle.
REQ-033 Input 1 granted, out_ready toggles 1,0,0,1 over 3-beat packet -> beat_fire only when out_ready=1; release after 3rd fire.
REQ-034 MAX_BEATS=4, input 0 never asserts last -> timeout_err pulses once after 4th fire; pkt_count unchanged; next grant to input 1.
REQ-035 Input 3 granted, rst pulsed after 2 beats -> grant=0 next cycle, pkt_count=0, next grant to input 0.
REQ-036 Input 0 granted, req[0] drops mid-packet -> IDLE, no timeout_err, pkt_count unchanged, rr_ptr=1.
